fib_chain_sched: RTL and testbench
==================================

Name: fib_chain_sched

Overview:
- Sequential scheduler that time-multiplexes one Fibonacci-adder stage over a virtual chain of NSTAGE stages for the CAC Fibonacci-numeral codec datapath.
- Each step computes f(k) = f(k-1) + f(k-2), or bypasses when that stage's error flag is set (1 = error).
- Sits between the codec front end, which supplies seeds and the per-stage error mask, and the codeword mapper, which consumes the final pair.
- Replaces an NSTAGE-deep combinational adder chain with an NSTAGE-cycle iteration.

Parameters:
W, 8, datapath width of the a/b registers and the result.
NSTAGE, 8, number of virtual adder stages iterated per job (>=1).
CW, 4, width of step and bypass counters; must satisfy 2^CW > NSTAGE.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  job request; sampled only in IDLE.
seed_a  in  W  f(k-2) initial value.
seed_b  in  W  f(k-1) initial value.
err_mask  in  NSTAGE  per-stage error flags; bit k=1 bypasses stage k; captured with start.
abort  in  1  synchronous job cancel.
busy  out  1  high in RUN and DONE.
res_valid  out  1  result available (DONE state).
res_ready  in  1  consumer accepts the result.
res_a  out  W  final f(k-1) register.
res_b  out  W  final f(k) register.
ovf  out  1  sticky: some non-bypassed step wrapped modulo 2^W.
bypass_cnt  out  CW  number of bypassed stages in the job.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; a, b, step, bypass_cnt = 0; ovf=0; busy=0; res_valid=0. res_a/res_b read 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0: load a=seed_a, b=seed_b, mask_q=err_mask, step=0, ovf=0, bypass_cnt=0 → RUN.
  - abort has no effect in IDLE.
- RUN, one stage per cycle (edges E1..E_NSTAGE):
  - mask_q[step]=0: a<=b; b<=(a+b) mod 2^W; ovf<=ovf | carry-out.
  - mask_q[step]=1: a and b unchanged; bypass_cnt<=bypass_cnt+1. This matches stage error semantics: S_out=B_in, B_out=A_in.
  - step increments each cycle. When step==NSTAGE-1, the update is applied and the FSM goes → DONE.
- Latency: res_valid=1 after edge E_(NSTAGE+1) counted from the start edge E0, i.e. NSTAGE+1 cycles.
- DONE:
  - res_valid=1; res_a=a, res_b=b, ovf and bypass_cnt are held stable.
  - res_ready=1 → IDLE at the next edge; res_valid drops. Registers keep their values until the next start.
  - No new job is accepted in the same cycle as the handshake. The earliest next start is sampled in the following IDLE cycle.
- start while busy: ignored, not queued. err_mask and seed changes during RUN have no effect.
- abort=1 in RUN or DONE: → IDLE at the next edge; res_valid=0; no result is delivered. abort has priority over res_ready and over the step update.
- All-ones mask: the result equals the seeds, ovf=0, bypass_cnt=NSTAGE.
- rst_n low mid-job: immediate return to the reset state; the partial job is lost.
- Arithmetic is unsigned. The sum is computed at W+1 bits; bit W is the carry used for ovf and is discarded.

Decomposition:
- Shared package fib_cac_pkg holds:
  - FSM state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Default W and NSTAGE constants.
- One combinational sub-module, fib_step_unit:
  - Inputs: a, b, err.
  - Outputs: a_nxt, b_nxt, carry.
  - It is the parameterised equivalent of the existing stage adder with bypass and is instantiated once.
- The FSM, counters and result hold live in fib_chain_sched.

Test Plan:
- Seeds 1/1, mask 0x00, NSTAGE=8, res_ready=1 → res_valid asserts 9 cycles after start; res_a=34, res_b=55, bypass_cnt=0, ovf=0.
- Seeds 1/1, mask 0x05 (stages 0 and 2 bypassed) → res_a=13, res_b=21, bypass_cnt=2, ovf=0.
- Seeds 100/100, W=8, mask 0xFC (only stages 0,1 active) → step1 gives (100,200); step2 gives 300 mod 256, so res_a=200, res_b=44, ovf=1.
- Hold res_ready=0 for 5 cycles in DONE, pulse start → outputs stable, start ignored; res_ready=1 → IDLE, then a new start is accepted.
- Assert abort at step 3 of a job → IDLE next cycle, res_valid never asserted; a following job with seeds 2/3, mask 0x00 → res_b=144.
- Drop rst_n for one cycle mid-RUN (asynchronously, between edges) → busy=0, res_valid=0, ovf=0, bypass_cnt=0 immediately.

Source files
------------

// File: rtl/fib_cac_pkg.sv
// Shared types and default sizing for the CAC Fibonacci-numeral codec datapath.
package fib_cac_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fib_state_e;

   localparam int FIB_W_DEF      = 8;
   localparam int FIB_NSTAGE_DEF = 8;
   localparam int FIB_CW_DEF     = 4;

endpackage

// File: rtl/fib_chain_sched_if.sv
// Job request / result bus between the codec front end, the scheduler and the codeword mapper.
interface fib_chain_sched_if #(
   parameter int W      = 8,
   parameter int NSTAGE = 8,
   parameter int CW     = 4
);
   logic              start;
   logic [W-1:0]      seed_a;
   logic [W-1:0]      seed_b;
   logic [NSTAGE-1:0] err_mask;
   logic              abort;
   logic              busy;
   logic              res_valid;
   logic              res_ready;
   logic [W-1:0]      res_a;
   logic [W-1:0]      res_b;
   logic              ovf;
   logic [CW-1:0]     bypass_cnt;

   modport master (
      output start, seed_a, seed_b, err_mask, abort, res_ready,
      input  busy, res_valid, res_a, res_b, ovf, bypass_cnt
   );

   modport slave (
      input  start, seed_a, seed_b, err_mask, abort, res_ready,
      output busy, res_valid, res_a, res_b, ovf, bypass_cnt
   );
endinterface

// File: rtl/fib_step_unit.sv
// One Fibonacci adder stage with error bypass: (a,b) -> (b, a+b), or unchanged when err is set.
module fib_step_unit #(
   parameter int W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         err_i,
   output logic [W-1:0] a_nxt_o,
   output logic [W-1:0] b_nxt_o,
   output logic         carry_o
);
   logic [W:0] sum_s;

   assign sum_s = {1'b0, a_i} + {1'b0, b_i};

   // A bypassed stage passes its inputs through and can never flag a carry.
   always_comb begin
      a_nxt_o = a_i;
      b_nxt_o = b_i;
      carry_o = 1'b0;
      if (err_i) begin
         a_nxt_o = a_i;
         b_nxt_o = b_i;
         carry_o = 1'b0;
      end else begin
         a_nxt_o = b_i;
         b_nxt_o = sum_s[W-1:0];
         carry_o = sum_s[W];
      end
   end
endmodule

// File: rtl/fib_chain_sched.sv
// Iterates a single fib_step_unit over NSTAGE virtual stages per job and holds the final pair
// until the consumer accepts it.
module fib_chain_sched
   import fib_cac_pkg::*;
#(
   parameter int W      = FIB_W_DEF,
   parameter int NSTAGE = FIB_NSTAGE_DEF,
   parameter int CW     = FIB_CW_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   fib_chain_sched_if.slave  bus
);
   localparam logic [CW-1:0] STEP_LAST = CW'(NSTAGE - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   fib_state_e        state_q, state_d;
   logic [W-1:0]      a_q, a_d, b_q, b_d;
   logic [CW-1:0]     step_q, step_d, byp_q, byp_d;
   logic [NSTAGE-1:0] mask_q, mask_d;
   logic              ovf_q, ovf_d, busy_q, busy_d, valid_q, valid_d;

   logic [NSTAGE-1:0] mask_sh_s;
   logic              err_s, carry_s;
   logic [W-1:0]      a_nxt_s, b_nxt_s;

   assign mask_sh_s = mask_q >> step_q;
   assign err_s     = mask_sh_s[0];

   fib_step_unit #(.W(W)) u_step (
      .a_i     (a_q),
      .b_i     (b_q),
      .err_i   (err_s),
      .a_nxt_o (a_nxt_s),
      .b_nxt_o (b_nxt_s),
      .carry_o (carry_s)
   );

   // Next-state, datapath update and output decode.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      step_d  = step_q;
      byp_d   = byp_q;
      ovf_d   = ovf_q;
      mask_d  = mask_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.seed_a;
               b_d     = bus.seed_b;
               mask_d  = bus.err_mask;
               step_d  = '0;
               byp_d   = '0;
               ovf_d   = 1'b0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else begin
               a_d    = a_nxt_s;
               b_d    = b_nxt_s;
               ovf_d  = ovf_q | carry_s;
               step_d = step_q + CNT_ONE;
               if (err_s) begin
                  byp_d = byp_q + CNT_ONE;
               end else begin
                  byp_d = byp_q;
               end
               if (step_q == STEP_LAST) begin
                  state_d = DONE;
               end else begin
                  state_d = RUN;
               end
            end
         end
         DONE: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (valid_q && bus.res_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d  = (state_d != IDLE);
      // The result is presented one cycle after entering DONE, so latency is NSTAGE+1.
      valid_d = (state_q == DONE) && (state_d == DONE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         step_q  <= '0;
         byp_q   <= '0;
         mask_q  <= '0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         step_q  <= step_d;
         byp_q   <= byp_d;
         mask_q  <= mask_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.res_valid  = valid_q;
   assign bus.res_a      = a_q;
   assign bus.res_b      = b_q;
   assign bus.ovf        = ovf_q;
   assign bus.bypass_cnt = byp_q;
endmodule

// File: tb/tb_fib_chain_sched.sv
// Directed, table-driven bench for fib_chain_sched (W=8, NSTAGE=8, CW=4).
module tb_fib_chain_sched;
   localparam int W      = 8;
   localparam int NSTAGE = 8;
   localparam int CW     = 4;

   typedef struct {
      logic [7:0] sa;
      logic [7:0] sb;
      logic [7:0] m;
      logic [7:0] ea;
      logic [7:0] eb;
      logic       eovf;
      logic [3:0] ebyp;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;
   vec_t vecs [8];

   fib_chain_sched_if #(.W(W), .NSTAGE(NSTAGE), .CW(CW)) bus ();

   fib_chain_sched #(.W(W), .NSTAGE(NSTAGE), .CW(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      n_chk = n_chk + 1;
      if (act != exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Called right after a negedge; returns right after the negedge following E0.
   task automatic start_job(input logic [7:0] sa, input logic [7:0] sb, input logic [7:0] m);
      bus.start    = 1'b1;
      bus.seed_a   = sa;
      bus.seed_b   = sb;
      bus.err_mask = m;
      @(posedge clk);
      @(negedge clk);
      bus.start    = 1'b0;
      bus.seed_a   = 8'hFF;
      bus.seed_b   = 8'hFF;
      bus.err_mask = 8'h00;
      check("busy_after_start", int'(bus.busy), 1);
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!bus.res_valid && cyc < 40) begin
         @(posedge clk);
         @(negedge clk);
         cyc = cyc + 1;
      end
   endtask

   task automatic handshake();
      bus.res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.res_ready = 1'b0;
      check("valid_after_ack", int'(bus.res_valid), 0);
      check("busy_after_ack", int'(bus.busy), 0);
   endtask

   task automatic run_vec(input vec_t v);
      int cyc;
      start_job(v.sa, v.sb, v.m);
      wait_valid(cyc);
      check("latency", cyc, NSTAGE + 1);
      check("res_a", int'(bus.res_a), int'(v.ea));
      check("res_b", int'(bus.res_b), int'(v.eb));
      check("ovf", int'(bus.ovf), int'(v.eovf));
      check("bypass_cnt", int'(bus.bypass_cnt), int'(v.ebyp));
      handshake();
   endtask

   initial begin
      int  cyc;
      bit  seen;
      n_chk = 0;
      n_err = 0;
      vecs[0] = '{8'd1,   8'd1,   8'h00, 8'd34,  8'd55,  1'b0, 4'd0};
      vecs[1] = '{8'd1,   8'd1,   8'h05, 8'd13,  8'd21,  1'b0, 4'd2};
      vecs[2] = '{8'd100, 8'd100, 8'hFC, 8'd200, 8'd44,  1'b1, 4'd6};
      vecs[3] = '{8'd2,   8'd3,   8'h00, 8'd89,  8'd144, 1'b0, 4'd0};
      vecs[4] = '{8'd7,   8'd9,   8'hFF, 8'd7,   8'd9,   1'b0, 4'd8};
      vecs[5] = '{8'd1,   8'd1,   8'h80, 8'd21,  8'd34,  1'b0, 4'd1};
      vecs[6] = '{8'd200, 8'd100, 8'hFE, 8'd100, 8'd44,  1'b1, 4'd7};
      vecs[7] = '{8'd128, 8'd128, 8'h00, 8'd0,   8'd128, 1'b1, 4'd0};

      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.seed_a    = 8'd0;
      bus.seed_b    = 8'd0;
      bus.err_mask  = 8'h00;
      bus.abort     = 1'b0;
      bus.res_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_valid", int'(bus.res_valid), 0);
      check("rst_res_a", int'(bus.res_a), 0);
      check("rst_res_b", int'(bus.res_b), 0);
      check("rst_ovf", int'(bus.ovf), 0);
      check("rst_byp", int'(bus.bypass_cnt), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i]);
      end

      // Result held under back-pressure; start ignored in DONE and during the handshake.
      start_job(8'd1, 8'd1, 8'h00);
      wait_valid(cyc);
      check("hold_latency", cyc, NSTAGE + 1);
      for (int i = 0; i < 5; i++) begin
         bus.start  = (i == 2);
         bus.seed_a = 8'd5;
         bus.seed_b = 8'd5;
         @(posedge clk);
         @(negedge clk);
         bus.start = 1'b0;
         check("hold_valid", int'(bus.res_valid), 1);
         check("hold_res_a", int'(bus.res_a), 34);
         check("hold_res_b", int'(bus.res_b), 55);
      end
      bus.start = 1'b1;
      handshake();
      bus.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("idle_after_hold", int'(bus.busy), 0);
      run_vec(vecs[3]);

      // Abort at step 3: no result, then a clean job.
      start_job(8'd1, 8'd1, 8'h00);
      repeat (3) @(posedge clk);
      @(negedge clk);
      bus.abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.abort = 1'b0;
      check("abort_busy", int'(bus.busy), 0);
      check("abort_valid", int'(bus.res_valid), 0);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.res_valid) seen = 1'b1;
      end
      check("abort_no_result", int'(seen), 0);
      run_vec(vecs[3]);

      // abort is ignored in IDLE: a start alongside it is still accepted.
      bus.abort = 1'b1;
      start_job(8'd1, 8'd1, 8'h00);
      bus.abort = 1'b0;
      wait_valid(cyc);
      check("idle_abort_latency", cyc, NSTAGE + 1);
      check("idle_abort_res_b", int'(bus.res_b), 55);
      handshake();

      // Asynchronous reset mid-RUN after ovf and bypass_cnt have become non-zero.
      start_job(8'd128, 8'd128, 8'h02);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("pre_rst_ovf", int'(bus.ovf), 1);
      check("pre_rst_byp", int'(bus.bypass_cnt), 1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", int'(bus.busy), 0);
      check("midrst_valid", int'(bus.res_valid), 0);
      check("midrst_ovf", int'(bus.ovf), 0);
      check("midrst_byp", int'(bus.bypass_cnt), 0);
      check("midrst_res_b", int'(bus.res_b), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_vec(vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end
endmodule
